// File: rtl/pipe_pack.sv
// pipe_pack: gathers RATIO narrow input beats into one wide output word.
// A beat carrying in_last closes the word early so packets never share a word.
module pipe_pack #(
  parameter int IN_WIDTH = 64,
  parameter int RATIO    = 4,
  localparam int OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [RATIO-1:0]     out_keep,
  output logic                 out_last,
  input  logic                 out_ready
);

  localparam int CW = $clog2(RATIO);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX  = CW'(RATIO - 1);

  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_nx_s;
  logic [OUT_WIDTH-1:0] data_r;
  logic [OUT_WIDTH-1:0] data_nx_s;
  logic [RATIO-1:0]     keep_r;
  logic [RATIO-1:0]     keep_nx_s;
  logic                 last_r;
  logic                 last_nx_s;
  logic                 full_r;
  logic                 full_nx_s;
  logic                 in_hs_s;
  logic                 out_hs_s;

  // A held word may be replaced in the same cycle it is retired downstream.
  assign in_ready  = !full_r || out_ready;
  assign in_hs_s   = in_valid && in_ready;
  assign out_hs_s  = full_r && out_ready;
  assign out_valid = full_r;
  assign out_data  = data_r;
  assign out_keep  = keep_r;
  assign out_last  = last_r;

  // Next-state: lane write, word completion, and retire on output handshake
  always_comb begin
    cnt_nx_s  = cnt_r;
    data_nx_s = data_r;
    keep_nx_s = keep_r;
    last_nx_s = last_r;
    full_nx_s = full_r;
    if (in_hs_s) begin
      if (cnt_r == CNT_ZERO) begin
        data_nx_s = '0;
        keep_nx_s = '0;
      end else begin
        data_nx_s = data_r;
        keep_nx_s = keep_r;
      end
      for (int k = 0; k < RATIO; k++) begin
        data_nx_s[k*IN_WIDTH +: IN_WIDTH] = (cnt_r == CW'(k)) ? in_data
                                          : data_nx_s[k*IN_WIDTH +: IN_WIDTH];
        keep_nx_s[k] = (cnt_r == CW'(k)) ? 1'b1 : keep_nx_s[k];
      end
      if ((cnt_r == CNT_MAX) || in_last) begin
        full_nx_s = 1'b1;
        last_nx_s = in_last;
        cnt_nx_s  = CNT_ZERO;
      end else begin
        full_nx_s = 1'b0;
        last_nx_s = last_r;
        cnt_nx_s  = cnt_r + CW'(1);
      end
    end else if (out_hs_s) begin
      full_nx_s = 1'b0;
    end else begin
      full_nx_s = full_r;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r  <= CNT_ZERO;
      data_r <= '0;
      keep_r <= '0;
      last_r <= 1'b0;
      full_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nx_s;
      data_r <= data_nx_s;
      keep_r <= keep_nx_s;
      last_r <= last_nx_s;
      full_r <= full_nx_s;
    end
  end

endmodule

// File: tb/tb_pipe_pack.sv
// Bench for pipe_pack: directed scenarios on a RATIO=4 instance, random traffic
// on a RATIO=3 instance, both checked by scoreboards fed from observed handshakes.
module tb_pipe_pack;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, in_valid_a, in_last_a, in_ready_a;
  logic        out_valid_a, out_last_a, out_ready_a;
  logic [7:0]  in_data_a;
  logic [31:0] out_data_a;
  logic [3:0]  out_keep_a;

  logic        reset_b, in_valid_b, in_last_b, in_ready_b;
  logic        out_valid_b, out_last_b, out_ready_b;
  logic [7:0]  in_data_b;
  logic [23:0] out_data_b;
  logic [2:0]  out_keep_b;

  pipe_pack #(.IN_WIDTH(8), .RATIO(4)) dut_a (
    .clk(clk), .reset(reset_a), .in_valid(in_valid_a), .in_data(in_data_a),
    .in_last(in_last_a), .in_ready(in_ready_a), .out_valid(out_valid_a),
    .out_data(out_data_a), .out_keep(out_keep_a), .out_last(out_last_a),
    .out_ready(out_ready_a)
  );

  pipe_pack #(.IN_WIDTH(8), .RATIO(3)) dut_b (
    .clk(clk), .reset(reset_b), .in_valid(in_valid_b), .in_data(in_data_b),
    .in_last(in_last_b), .in_ready(in_ready_b), .out_valid(out_valid_b),
    .out_data(out_data_b), .out_keep(out_keep_b), .out_last(out_last_b),
    .out_ready(out_ready_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit run_a    = 1'b0;
  bit run_b    = 1'b0;

  word_t       exp_a[$];
  word_t       exp_b[$];
  int          hs_cyc_a[$];
  logic [31:0] cur_data_a = 32'd0;
  logic [31:0] cur_data_b = 32'd0;
  int          cur_n_a = 0;
  int          cur_n_b = 0;
  int          words_b = 0;
  int          made_b  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t mk(input logic [31:0] d, input int n, input logic l);
    word_t w;
    w.data = d;
    w.keep = 4'((1 << n) - 1);
    w.last = l;
    return w;
  endfunction

  task automatic drive_a(input logic v, input logic [7:0] d, input logic l);
    @(posedge clk);
    #1;
    in_valid_a = v;
    in_data_a  = d;
    in_last_a  = l;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc <= cyc + 1;
    end
  end

  // Scoreboard for instance A: one pending word means the DUT must be holding it.
  initial begin
    forever begin
      @(negedge clk);
      if (run_a) begin
        chk("a_in_ready", 32'(in_ready_a), 32'((exp_a.size() == 0) || out_ready_a));
        chk("a_out_valid", 32'(out_valid_a), 32'(exp_a.size() != 0));
        if (out_valid_a && (exp_a.size() != 0)) begin
          chk("a_data", out_data_a, exp_a[0].data);
          chk("a_keep", 32'(out_keep_a), 32'(exp_a[0].keep));
          chk("a_last", 32'(out_last_a), 32'(exp_a[0].last));
          if (out_ready_a) begin
            void'(exp_a.pop_front());
            hs_cyc_a.push_back(cyc);
          end
        end
        if (reset_a) begin
          cur_n_a = 0;
          cur_data_a = 32'd0;
          exp_a.delete();
        end else if (in_valid_a && in_ready_a) begin
          cur_data_a = cur_data_a | (32'(in_data_a) << (8 * cur_n_a));
          cur_n_a++;
          if ((cur_n_a == 4) || in_last_a) begin
            exp_a.push_back(mk(cur_data_a, cur_n_a, in_last_a));
            cur_n_a = 0;
            cur_data_a = 32'd0;
          end
        end
      end
    end
  end

  // Scoreboard for instance B (three lanes per word).
  initial begin
    forever begin
      @(negedge clk);
      if (run_b) begin
        chk("b_in_ready", 32'(in_ready_b), 32'((exp_b.size() == 0) || out_ready_b));
        chk("b_out_valid", 32'(out_valid_b), 32'(exp_b.size() != 0));
        if (out_valid_b && (exp_b.size() != 0)) begin
          chk("b_data", 32'(out_data_b), exp_b[0].data);
          chk("b_keep", 32'(out_keep_b), 32'(exp_b[0].keep));
          chk("b_last", 32'(out_last_b), 32'(exp_b[0].last));
          if (out_ready_b) begin
            void'(exp_b.pop_front());
            words_b++;
          end
        end
        if (in_valid_b && in_ready_b) begin
          cur_data_b = cur_data_b | (32'(in_data_b) << (8 * cur_n_b));
          cur_n_b++;
          if ((cur_n_b == 3) || in_last_b) begin
            exp_b.push_back(mk(cur_data_b, cur_n_b, in_last_b));
            made_b++;
            cur_n_b = 0;
            cur_data_b = 32'd0;
          end
        end
      end
    end
  end

  initial begin
    reset_a = 1'b1; in_valid_a = 1'b0; in_data_a = 8'h00; in_last_a = 1'b0; out_ready_a = 1'b1;
    reset_b = 1'b1; in_valid_b = 1'b0; in_data_b = 8'h00; in_last_b = 1'b0; out_ready_b = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_a = 1'b0;
    @(negedge clk);
    chk("a_rst_valid", 32'(out_valid_a), 32'd0);
    chk("a_rst_keep", 32'(out_keep_a), 32'd0);
    chk("a_rst_data", out_data_a, 32'd0);
    chk("a_rst_last", 32'(out_last_a), 32'd0);
    chk("a_rst_ready", 32'(in_ready_a), 32'd1);
    run_a = 1'b1;

    // Full word of four beats, last on the fourth
    drive_a(1'b1, 8'h11, 1'b0);
    drive_a(1'b1, 8'h22, 1'b0);
    drive_a(1'b1, 8'h33, 1'b0);
    drive_a(1'b1, 8'h44, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("a_full_valid", 32'(out_valid_a), 32'd1);
    chk("a_full_data", out_data_a, 32'h44332211);
    chk("a_full_keep", 32'(out_keep_a), 32'hF);
    chk("a_full_last", 32'(out_last_a), 32'd1);

    // Early last, then the next beat starts a fresh word
    drive_a(1'b1, 8'hA1, 1'b0);
    drive_a(1'b1, 8'hA2, 1'b1);
    drive_a(1'b1, 8'hB1, 1'b0);
    @(negedge clk);
    chk("a_early_data", out_data_a, 32'h0000A2A1);
    chk("a_early_keep", 32'(out_keep_a), 32'h3);
    chk("a_early_last", 32'(out_last_a), 32'd1);
    drive_a(1'b1, 8'hB2, 1'b1);
    drive_a(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("a_next_data", out_data_a, 32'h0000B2B1);
    chk("a_next_keep", 32'(out_keep_a), 32'h3);

    // Backpressure: held word stays put and the waiting beat is refused
    drive_a(1'b1, 8'h21, 1'b0);
    out_ready_a = 1'b0;
    drive_a(1'b1, 8'h22, 1'b0);
    drive_a(1'b1, 8'h23, 1'b0);
    drive_a(1'b1, 8'h24, 1'b0);
    drive_a(1'b1, 8'h55, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("a_bp_ready", 32'(in_ready_a), 32'd0);
      chk("a_bp_data", out_data_a, 32'h24232221);
      chk("a_bp_keep", 32'(out_keep_a), 32'hF);
      chk("a_bp_last", 32'(out_last_a), 32'd0);
    end
    @(posedge clk);
    #1 out_ready_a = 1'b1;
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    @(negedge clk);
    chk("a_bp_new_data", out_data_a, 32'h00000055);
    chk("a_bp_new_keep", 32'(out_keep_a), 32'h1);
    chk("a_bp_new_last", 32'(out_last_a), 32'd1);

    // Continuous stream of 12 beats: one word every 4 cycles
    @(posedge clk);
    hs_cyc_a.delete();
    for (int i = 0; i < 12; i++) begin
      drive_a(1'b1, 8'(8'h60 + i), (i == 11));
    end
    drive_a(1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    chk("a_stream_words", 32'(hs_cyc_a.size()), 32'd3);
    if (hs_cyc_a.size() >= 3) begin
      chk("a_stream_gap1", 32'(hs_cyc_a[1] - hs_cyc_a[0]), 32'd4);
      chk("a_stream_gap2", 32'(hs_cyc_a[2] - hs_cyc_a[1]), 32'd4);
    end

    // Reset mid-word, with a beat offered in the reset cycle
    drive_a(1'b1, 8'h91, 1'b0);
    drive_a(1'b1, 8'h92, 1'b0);
    @(posedge clk);
    #1;
    reset_a = 1'b1; in_data_a = 8'h93;
    @(posedge clk);
    #1;
    reset_a = 1'b0; in_valid_a = 1'b0;
    @(negedge clk);
    chk("a_mid_rst_valid", 32'(out_valid_a), 32'd0);
    chk("a_mid_rst_ready", 32'(in_ready_a), 32'd1);
    drive_a(1'b1, 8'h01, 1'b0);
    drive_a(1'b1, 8'h02, 1'b0);
    drive_a(1'b1, 8'h03, 1'b0);
    drive_a(1'b1, 8'h04, 1'b0);
    drive_a(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("a_post_rst_data", out_data_a, 32'h04030201);
    chk("a_post_rst_keep", 32'(out_keep_a), 32'hF);
    chk("a_post_rst_last", 32'(out_last_a), 32'd0);

    // Random traffic on the three-lane instance
    @(posedge clk);
    #1 reset_b = 1'b0;
    @(negedge clk);
    chk("b_rst_valid", 32'(out_valid_b), 32'd0);
    chk("b_rst_keep", 32'(out_keep_b), 32'd0);
    chk("b_rst_data", 32'(out_data_b), 32'd0);
    chk("b_rst_ready", 32'(in_ready_b), 32'd1);
    run_b = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      in_valid_b  = ($urandom_range(0, 99) < 70);
      in_data_b   = 8'($urandom);
      in_last_b   = ($urandom_range(0, 3) == 0);
      out_ready_b = ($urandom_range(0, 99) < 65);
    end
    @(posedge clk);
    #1;
    in_valid_b = 1'b0; out_ready_b = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("b_drained", 32'(exp_b.size()), 32'd0);
    chk("b_word_count", 32'(words_b), 32'(made_b));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
